ceespu_fetch: RTL and testbench
===============================

# ceespu_fetch

Instruction fetch stage between `ceespu_pc` and decode. Each cycle it samples the current PC, issues an in-order read to instruction memory, tags each response with its PC and buffers it for decode. It holds the PC through `O_stall` when its credit runs out, and flushes in-flight and buffered instructions on a branch. Together with the PC register it forms the complete PC→instruction path.

## Interface
- `DEPTH`, default 4: total credits, counting in-flight requests, responses still to be discarded and buffered entries. Range 2..8.
- `I_clk`  in  1: clock, rising edge.
- `I_rst`  in  1: asynchronous reset, active-high.
- `I_pc`  in  14: current PC from the PC register.
- `I_branch`  in  1: branch taken this cycle. The PC loads the target on the next edge.
- `O_stall`  out  1: the PC register must not increment.
- `O_imem_req`  out  1: read request, one cycle per request.
- `O_imem_addr`  out  14: request address. Equals `I_pc` when `O_imem_req` is high.
- `I_imem_valid`  in  1: read data valid. Responses arrive in order, latency ≥1 cycle, no backpressure.
- `I_imem_data`  in  32: read data.
- `O_valid`  out  1: the buffer head holds an instruction.
- `O_inst`  out  32: head instruction.
- `O_inst_pc`  out  14: PC of the head instruction.
- `I_ready`  in  1: decode accepts the head. A pop occurs when `O_valid & I_ready`.

## Operation
- Registered state:
  - `primed` flag.
  - `inflight` count.
  - `discard` count.
  - PC tag queue (DEPTH entries).
  - Output FIFO (DEPTH × 46 bits).
  - `used` = inflight + discard + FIFO occupancy. Computed from registered values only; a pop in the same cycle does not free a credit until the next cycle.
- Priming:
  - After reset, `primed` = 0 for exactly one cycle.
  - In that cycle: `O_stall` = 0 and no request is issued. The PC steps from 0x3FFF to 0x0000.
  - `primed` is set at the following edge.
- Issue condition: `issue = primed & ~I_branch & ~I_rst & (used < DEPTH)`.
  - `O_imem_req = issue`, `O_imem_addr = I_pc`.
  - On issue, `I_pc` is pushed to the tag queue and `inflight` is incremented.
- Stall:
  - `O_stall = primed & ~issue`.
  - During a branch cycle `O_stall` = 1; the PC register gives branch priority anyway.
- Response:
  - If `discard` > 0: the data is dropped and `discard` is decremented.
  - Otherwise: pop the tag queue, push {tag, data} into the FIFO, and decrement `inflight`.
- Flush (`I_branch` = 1):
  - Clear the FIFO at the edge.
  - `discard` ← `discard` + `inflight` − (1 if a non-discarded response arrives this cycle, dropped); `inflight` ← 0; clear the tag queue.
  - A pop in the flush cycle still completes for decode, but the FIFO is empty next cycle.
  - The first post-branch request is issued in the next cycle, with `I_pc` equal to the target.
- Simultaneous issue + response + pop: all three take effect in the same edge. Counts stay consistent and never exceed DEPTH.
- Outputs:
  - `O_valid` = FIFO not empty.
  - `O_inst` and `O_inst_pc` are driven from the head entry and are combinationally stable while `O_valid` is high and there is no pop.

## Timing
- Reset values: `O_stall` = 0, `O_imem_req` = 0, `O_imem_addr` = 0, `O_valid` = 0, `O_inst` = 0, `O_inst_pc` = 0, all counts 0, `primed` = 0.
- Reset asserted mid-operation clears everything asynchronously. Responses from before reset are not expected; the memory is reset together with this block.
- Latency with memory latency L:
  - Request at cycle t, response at t+L, `O_valid` at t+L+1.
  - Fetch-to-decode latency is L+1 cycles.
- Sustained throughput of 1 instruction per cycle requires DEPTH ≥ L+2 with `I_ready` held high. Otherwise the stage stalls periodically.
- No combinational path from `I_imem_valid` to `O_valid`.
- `O_stall` depends combinationally on `I_branch` only.

## Test plan
- Reset release, L=1, `I_ready`=1, memory returns data = 0xA000_0000 | addr:
  - Cycle 0: `O_stall`=0, no request.
  - Requests for 0, 1, 2, … on consecutive cycles.
  - `O_valid` first rises at cycle 3 with `O_inst_pc`=0, `O_inst`=0xA0000000, then one instruction per cycle.
- DEPTH=4, L=1, `I_ready`=0:
  - Exactly 4 requests (addresses 0..3), then `O_stall`=1 and `O_imem_req`=0.
  - Raising `I_ready` pops 0, 1, 2, 3 in order; requests resume one cycle after the first pop.
- L=3, two requests in flight, `I_branch`=1 with target 0x0100:
  - FIFO empties.
  - Both late responses are dropped.
  - The next `O_valid` entry has `O_inst_pc`=0x0100.
- Branch in the same cycle as a response and a pop:
  - The popped instruction is delivered.
  - The arriving response is dropped.
  - `discard` equals `inflight` − 1; no stale PC ever appears.
- Reset asserted while FIFO holds 2 entries and 1 request is in flight:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - Priming cycle repeats after release.
- PC wrap: run from 0x3FFE with a full stream. Tags 0x3FFE, 0x3FFF, 0x0000 are delivered in order.

Source files
------------

// File: rtl/ceespu_fetch.sv
// ---------------------------------------------------------------------------
// ceespu_fetch
//
// Instruction fetch stage sitting between the PC register and decode.
// Every cycle it samples the current PC, issues an in-order read to the
// instruction memory, tags each returning word with the PC it was fetched
// from and buffers the {pc, instruction} pair for decode. A credit scheme
// (in-flight requests + responses still to be thrown away + buffered
// entries) bounds the work outstanding to DEPTH; when no credit is left the
// PC register is told to hold. A taken branch flushes the buffer and marks
// every in-flight request as "discard on return".
//
// Ports
//   I_clk         clock, rising edge
//   I_rst         asynchronous reset, active high
//   I_pc          current PC from the PC register
//   I_branch      branch taken this cycle (PC loads the target next edge)
//   O_stall       PC register must not increment
//   O_imem_req    single-cycle read request
//   O_imem_addr   read address (I_pc while O_imem_req is high, else 0)
//   I_imem_valid  read data valid (in order, latency >= 1, no backpressure)
//   I_imem_data   read data
//   O_valid       buffer head holds an instruction
//   O_inst        head instruction
//   O_inst_pc     PC of the head instruction
//   I_ready       decode accepts the head (pop on O_valid & I_ready)
// ---------------------------------------------------------------------------
module ceespu_fetch #(
  parameter int DEPTH = 4
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [13:0] I_pc,
  input  logic        I_branch,
  output logic        O_stall,
  output logic        O_imem_req,
  output logic [13:0] O_imem_addr,
  input  logic        I_imem_valid,
  input  logic [31:0] I_imem_data,
  output logic        O_valid,
  output logic [31:0] O_inst,
  output logic [13:0] O_inst_pc,
  input  logic        I_ready
);

  // Pointer width, count width (must hold DEPTH itself) and a credit-sum
  // width wide enough that adding three counts can never wrap.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int UW = CW + 2;

  // Registered state
  logic          primed;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_cnt;
  logic [PW-1:0] tag_rd;
  logic [PW-1:0] tag_wr;
  logic [PW-1:0] fifo_rd;
  logic [PW-1:0] fifo_wr;
  logic [13:0]   tag_mem  [DEPTH];
  logic [45:0]   fifo_mem [DEPTH];

  // Combinational decisions for this cycle
  logic [UW-1:0] used;
  logic          issue;
  logic          resp_drop;
  logic          resp_keep;
  logic          push;
  logic          pop;
  logic          fifo_nempty;

  // Circular pointer increment; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(DEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + 1'b1;
    end
    return n;
  endfunction

  // Credit accounting and per-cycle issue/response/pop decisions.
  // Credits come from registered counts only, so a pop this cycle frees
  // its credit one cycle later.
  always_comb begin
    used        = UW'(inflight) + UW'(discard) + UW'(fifo_cnt);
    issue       = primed & ~I_branch & ~I_rst & (used < UW'(DEPTH));
    resp_drop   = I_imem_valid & (discard != '0);
    resp_keep   = I_imem_valid & (discard == '0);
    // A kept response in a flush cycle consumes its tag but is not buffered.
    push        = resp_keep & ~I_branch;
    fifo_nempty = (fifo_cnt != '0);
    pop         = fifo_nempty & I_ready;
  end

  // Memory request and PC-hold outputs.
  always_comb begin
    O_stall    = primed & ~issue;
    O_imem_req = issue;
    if (issue) begin
      O_imem_addr = I_pc;
    end else begin
      O_imem_addr = 14'd0;
    end
  end

  // Decode-facing outputs straight from the buffer head; forced to zero
  // when empty so stale entries never show.
  always_comb begin
    O_valid = fifo_nempty;
    if (fifo_nempty) begin
      O_inst    = fifo_mem[fifo_rd][31:0];
      O_inst_pc = fifo_mem[fifo_rd][45:32];
    end else begin
      O_inst    = 32'd0;
      O_inst_pc = 14'd0;
    end
  end

  // Priming flag and the in-flight / discard credit counters.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      primed   <= 1'b0;
      inflight <= '0;
      discard  <= '0;
    end else begin
      primed <= 1'b1;
      if (I_branch) begin
        // Everything still in flight becomes a response to throw away; a
        // response arriving right now is already out of the pipe.
        inflight <= '0;
        discard  <= discard - CW'(resp_drop) + inflight - CW'(resp_keep);
      end else begin
        inflight <= inflight + CW'(issue) - CW'(resp_keep);
        discard  <= discard - CW'(resp_drop);
      end
    end
  end

  // PC tag queue: one entry per outstanding kept request, in issue order.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      tag_rd <= '0;
      tag_wr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem[i] <= 14'd0;
      end
    end else if (I_branch) begin
      tag_rd <= '0;
      tag_wr <= '0;
    end else begin
      if (issue) begin
        tag_mem[tag_wr] <= I_pc;
        tag_wr          <= ptr_inc(tag_wr);
      end else begin
        tag_wr <= tag_wr;
      end
      if (resp_keep) begin
        tag_rd <= ptr_inc(tag_rd);
      end else begin
        tag_rd <= tag_rd;
      end
    end
  end

  // Output FIFO of {pc, instruction}; cleared on a branch after any pop
  // in the same cycle has been handed to decode.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      fifo_rd  <= '0;
      fifo_wr  <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= 46'd0;
      end
    end else if (I_branch) begin
      fifo_rd  <= '0;
      fifo_wr  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[fifo_wr] <= {tag_mem[tag_rd], I_imem_data};
        fifo_wr           <= ptr_inc(fifo_wr);
      end else begin
        fifo_wr <= fifo_wr;
      end
      if (pop) begin
        fifo_rd <= ptr_inc(fifo_rd);
      end else begin
        fifo_rd <= fifo_rd;
      end
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_ceespu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ceespu_fetch
//
// Self-checking bench for ceespu_fetch (DEPTH = 4). The bench plays the PC
// register (reset value chosen per scenario, +1 when not stalled, target on
// branch) and a fixed-latency instruction memory returning
// 0xA000_0000 | addr. A queue-based model of the fetch stage predicts the
// outputs each cycle; literal expectations pin delivery order and timing.
// ---------------------------------------------------------------------------
module tb_ceespu_fetch;

  localparam int DEPTH = 4;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic [13:0] I_pc;
  logic        I_branch;
  logic        O_stall;
  logic        O_imem_req;
  logic [13:0] O_imem_addr;
  logic        I_imem_valid;
  logic [31:0] I_imem_data;
  logic        O_valid;
  logic [31:0] O_inst;
  logic [13:0] O_inst_pc;
  logic        I_ready;

  ceespu_fetch #(.DEPTH(DEPTH)) dut (
    .I_clk        (I_clk),
    .I_rst        (I_rst),
    .I_pc         (I_pc),
    .I_branch     (I_branch),
    .O_stall      (O_stall),
    .O_imem_req   (O_imem_req),
    .O_imem_addr  (O_imem_addr),
    .I_imem_valid (I_imem_valid),
    .I_imem_data  (I_imem_data),
    .O_valid      (O_valid),
    .O_inst       (O_inst),
    .O_inst_pc    (O_inst_pc),
    .I_ready      (I_ready)
  );

  always #5 I_clk = ~I_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;

  // Model state
  logic [13:0] m_pc;
  bit          m_primed;
  logic [13:0] m_tags[$];
  int          m_discard;
  logic [45:0] m_fifo[$];
  int          mem_due[$];
  logic [13:0] mem_addr[$];

  // Logs of what the DUT actually did
  logic [13:0] del_pc[$];
  logic [31:0] del_inst[$];
  int          del_cyc[$];
  int          req_cyc[$];
  logic [13:0] req_addr[$];

  task automatic chk(input string name, input logic [45:0] act, input logic [45:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset(input logic [13:0] pc0);
    I_rst        = 1'b1;
    I_branch     = 1'b0;
    I_ready      = 1'b0;
    I_imem_valid = 1'b0;
    I_imem_data  = 32'd0;
    I_pc         = pc0;
    m_tags.delete();
    m_fifo.delete();
    mem_due.delete();
    mem_addr.delete();
    del_pc.delete();
    del_inst.delete();
    del_cyc.delete();
    req_cyc.delete();
    req_addr.delete();
    m_primed  = 1'b0;
    m_discard = 0;
    m_pc      = pc0;
    repeat (2) @(negedge I_clk);
    chk("rst_stall", O_stall, 1'b0);
    chk("rst_req", O_imem_req, 1'b0);
    chk("rst_addr", O_imem_addr, 14'd0);
    chk("rst_valid", O_valid, 1'b0);
    chk("rst_inst", O_inst, 32'd0);
    chk("rst_inst_pc", O_inst_pc, 14'd0);
    I_rst = 1'b0;
    cyc   = 0;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare against
  // the model, advance the model, then move to the next falling edge.
  task automatic run_cycle(input bit br, input logic [13:0] tgt, input bit rdy);
    int          used;
    bit          e_issue;
    bit          e_stall;
    bit          e_valid;
    bit          mv;
    logic [31:0] md;
    logic [13:0] a;
    logic [45:0] f;
    int          d;
    I_branch = br;
    I_ready  = rdy;
    I_pc     = m_pc;
    mv = 1'b0;
    md = 32'd0;
    if (mem_due.size() > 0 && mem_due[0] == cyc) begin
      d  = mem_due.pop_front();
      a  = mem_addr.pop_front();
      mv = 1'b1;
      md = 32'hA000_0000 | {18'd0, a};
    end
    I_imem_valid = mv;
    I_imem_data  = md;
    #1;
    used    = m_tags.size() + m_discard + m_fifo.size();
    e_issue = m_primed && !br && (used < DEPTH);
    e_stall = m_primed && !e_issue;
    e_valid = (m_fifo.size() > 0);
    chk("imem_req", O_imem_req, e_issue);
    chk("stall", O_stall, e_stall);
    chk("valid", O_valid, e_valid);
    if (e_issue) chk("imem_addr", O_imem_addr, m_pc);
    if (e_valid) begin
      chk("inst_pc", O_inst_pc, m_fifo[0][45:32]);
      chk("inst", O_inst, m_fifo[0][31:0]);
    end
    if (O_valid && rdy) begin
      del_pc.push_back(O_inst_pc);
      del_inst.push_back(O_inst);
      del_cyc.push_back(cyc);
    end
    if (O_imem_req) begin
      req_cyc.push_back(cyc);
      req_addr.push_back(O_imem_addr);
    end
    // Model update at the coming rising edge
    if (e_valid && rdy) f = m_fifo.pop_front();
    if (mv) begin
      if (m_discard > 0) begin
        m_discard--;
      end else begin
        a = m_tags.pop_front();
        if (!br) m_fifo.push_back({a, md});
      end
    end
    if (br) begin
      m_fifo.delete();
      m_discard += m_tags.size();
      m_tags.delete();
    end
    if (e_issue) begin
      m_tags.push_back(m_pc);
      mem_due.push_back(cyc + lat);
      mem_addr.push_back(m_pc);
    end
    m_primed = 1'b1;
    if (br) m_pc = tgt;
    else if (!e_stall) m_pc = m_pc + 14'd1;
    @(negedge I_clk);
    cyc++;
  endtask

  initial begin
    // 1: streaming, L=1, decode always ready
    lat = 1;
    do_reset(14'h3FFF);
    for (int i = 0; i < 12; i++) run_cycle(1'b0, 14'd0, 1'b1);
    chk("s1_n_req", (req_cyc.size() >= 5), 1'b1);
    chk("s1_first_req_cyc", req_cyc[0], 46'd1);
    chk("s1_first_req_addr", req_addr[0], 14'h0000);
    chk("s1_n_del", (del_pc.size() >= 5), 1'b1);
    chk("s1_first_valid_cyc", del_cyc[0], 46'd3);
    chk("s1_first_inst", del_inst[0], 32'hA000_0000);
    for (int i = 0; i < 5; i++) begin
      chk("s1_del_pc", del_pc[i], 46'(i));
      chk("s1_del_cyc", del_cyc[i], 46'(i + 3));
    end

    // 2: decode blocked, credits run out after DEPTH requests
    lat = 1;
    do_reset(14'h3FFF);
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 14'd0, 1'b0);
    chk("s2_n_req", req_cyc.size(), 46'd4);
    for (int i = 0; i < 4; i++) chk("s2_req_addr", req_addr[i], 46'(i));
    chk("s2_stall_held", O_stall, 1'b1);
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 14'd0, 1'b1);
    chk("s2_n_del", (del_pc.size() >= 4), 1'b1);
    for (int i = 0; i < 4; i++) chk("s2_del_pc", del_pc[i], 46'(i));
    chk("s2_first_pop_cyc", del_cyc[0], 46'd10);
    chk("s2_resume_req_cyc", req_cyc[4], 46'd11);
    chk("s2_resume_req_addr", req_addr[4], 14'd4);

    // 3: L=3, branch with two requests in flight
    lat = 3;
    do_reset(14'h3FFF);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 14'd0, 1'b1);
    chk("s3_inflight_reqs", req_cyc.size(), 46'd2);
    run_cycle(1'b1, 14'h0100, 1'b1);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 14'd0, 1'b1);
    chk("s3_n_del", (del_pc.size() >= 2), 1'b1);
    chk("s3_first_pc", del_pc[0], 14'h0100);
    chk("s3_first_cyc", del_cyc[0], 46'd8);
    chk("s3_second_pc", del_pc[1], 14'h0101);

    // 4: branch coinciding with a response and a pop
    lat = 1;
    do_reset(14'h3FFF);
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 14'd0, 1'b1);
    run_cycle(1'b1, 14'h0200, 1'b1);
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 14'd0, 1'b1);
    chk("s4_n_del", (del_pc.size() >= 6), 1'b1);
    for (int i = 0; i < 4; i++) chk("s4_del_pc", del_pc[i], 46'(i));
    chk("s4_pop_in_branch_cyc", del_cyc[3], 46'd6);
    chk("s4_target_pc", del_pc[4], 14'h0200);
    chk("s4_target_cyc", del_cyc[4], 46'd9);
    chk("s4_target_next", del_pc[5], 14'h0201);

    // 5: asynchronous reset with 2 buffered entries and 1 request in flight
    lat = 1;
    do_reset(14'h3FFF);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 14'd0, 1'b0);
    #2;
    chk("s5_pre_valid", O_valid, 1'b1);
    chk("s5_pre_pc", O_inst_pc, 14'h0000);
    I_rst = 1'b1;
    #1;
    chk("s5_async_valid", O_valid, 1'b0);
    chk("s5_async_stall", O_stall, 1'b0);
    chk("s5_async_req", O_imem_req, 1'b0);
    chk("s5_async_addr", O_imem_addr, 14'd0);
    chk("s5_async_inst", O_inst, 32'd0);
    chk("s5_async_inst_pc", O_inst_pc, 14'd0);
    do_reset(14'h3FFF);
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 14'd0, 1'b1);
    chk("s5_rep_first_req", req_cyc[0], 46'd1);
    chk("s5_rep_first_del", del_cyc[0], 46'd3);
    chk("s5_rep_first_pc", del_pc[0], 14'h0000);

    // 6: PC wrap-around with a full stream
    lat = 1;
    do_reset(14'h3FFD);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 14'd0, 1'b1);
    chk("s6_n_del", (del_pc.size() >= 3), 1'b1);
    chk("s6_pc0", del_pc[0], 14'h3FFE);
    chk("s6_pc1", del_pc[1], 14'h3FFF);
    chk("s6_pc2", del_pc[2], 14'h0000);
    chk("s6_inst2", del_inst[2], 32'hA000_0000);
    chk("s6_inst0", del_inst[0], 32'hA000_3FFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
